// File: rtl/vga_sync_capture.sv
// Receive-side VGA timing capture: measures line/frame timing, locks on stable timing,
// regenerates pixel coordinates. Build macro SYNC_POL_DETECT_EN enables sync polarity detection.
module vga_sync_capture #(
  parameter int H_START     = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_START     = 35,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        R,
  input  logic        G,
  input  logic        B,
  output logic        locked,
  output logic [11:0] line_period,
  output logic [10:0] frame_lines,
  output logic        active,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [2:0]  pix_rgb,
  output logic        h_pol,
  output logic        v_pol
);
  localparam logic [11:0] H_LO      = 12'(H_START);
  localparam logic [11:0] H_HI      = 12'(H_START + H_ACTIVE);
  localparam logic [10:0] V_LO      = 11'(V_START);
  localparam logic [10:0] V_HI      = 11'(V_START + V_ACTIVE);
  localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);
  // {h, v, r, g, b}; syncs idle high so a stream already in sync yields a real edge after reset
  localparam logic [4:0]  SYNC_IDLE = 5'b11000;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t      state_q, state_d;
  logic [4:0]  sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d;
  logic [11:0] h_cnt_q, h_cnt_d, line_period_q, line_period_d, ref_line_q, ref_line_d;
  logic [10:0] v_cnt_q, v_cnt_d, frame_lines_q, frame_lines_d, ref_frame_q, ref_frame_d;
  logic [10:0] v_inc;
  logic [3:0]  match_q, match_d, match_inc;
  logic        locked_q, locked_d, active_q, active_d;
  logic        h_pol_q, h_pol_d, v_pol_q, v_pol_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [2:0]  pix_rgb_q, pix_rgb_d;
  logic        h_fall, v_fall, h_to, v_to, pol_chg, in_area;

  always_comb begin
    sync1_d = {h_sync, v_sync, R, G, B};
    sync2_d = sync1_q;
    dly_d   = sync2_q;
  end

`ifdef SYNC_POL_DETECT_EN
  logic [11:0] h_lo_q, h_lo_d, h_hi_q, h_hi_d;
  logic [19:0] v_lo_q, v_lo_d, v_hi_q, v_hi_d;
  logic        h_raw_fall, v_raw_fall;

  // Phase lengths are accumulated between raw falling edges; the shorter phase is the pulse.
  always_comb begin
    h_raw_fall = dly_q[4] & ~sync2_q[4];
    v_raw_fall = dly_q[3] & ~sync2_q[3];
    h_lo_d  = h_lo_q;
    h_hi_d  = h_hi_q;
    v_lo_d  = v_lo_q;
    v_hi_d  = v_hi_q;
    h_pol_d = h_pol_q;
    v_pol_d = v_pol_q;
    if (dly_q[4]) begin
      if (h_hi_q != '1) h_hi_d = h_hi_q + 12'd1;
    end else if (h_lo_q != '1) h_lo_d = h_lo_q + 12'd1;
    if (dly_q[3]) begin
      if (v_hi_q != '1) v_hi_d = v_hi_q + 20'd1;
    end else if (v_lo_q != '1) v_lo_d = v_lo_q + 20'd1;
    if (h_raw_fall) begin
      h_pol_d = (h_hi_q < h_lo_q);
      h_lo_d  = '0;
      h_hi_d  = '0;
    end
    if (v_raw_fall) begin
      v_pol_d = (v_hi_q < v_lo_q);
      v_lo_d  = '0;
      v_hi_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_lo_q <= '0;
      h_hi_q <= '0;
      v_lo_q <= '0;
      v_hi_q <= '0;
    end else begin
      h_lo_q <= h_lo_d;
      h_hi_q <= h_hi_d;
      v_lo_q <= v_lo_d;
      v_hi_q <= v_hi_d;
    end
  end
`else
  always_comb begin
    h_pol_d = 1'b0;
    v_pol_d = 1'b0;
  end
`endif

  // Leading edge of the sync pulse: normalising by polarity makes it a falling edge.
  always_comb begin
    h_fall  = (dly_q[4] ^ h_pol_q) & ~(sync2_q[4] ^ h_pol_q);
    v_fall  = (dly_q[3] ^ v_pol_q) & ~(sync2_q[3] ^ v_pol_q);
    pol_chg = (h_pol_d != h_pol_q) | (v_pol_d != v_pol_q);
  end

  always_comb begin
    h_to          = (h_cnt_q == 12'hFFF);
    v_to          = (v_cnt_q == 11'h7FF);
    v_inc         = v_to ? v_cnt_q : v_cnt_q + 11'd1;
    h_cnt_d       = h_to ? h_cnt_q : h_cnt_q + 12'd1;
    v_cnt_d       = v_cnt_q;
    line_period_d = line_period_q;
    frame_lines_d = frame_lines_q;
    if (h_fall) begin
      line_period_d = h_to ? 12'hFFF : h_cnt_q + 12'd1;
      h_cnt_d       = '0;
      v_cnt_d       = v_inc;
    end
    if (v_fall) begin
      frame_lines_d = h_fall ? v_inc : v_cnt_q;
      v_cnt_d       = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    ref_line_d  = ref_line_q;
    ref_frame_d = ref_frame_q;
    match_d     = match_q;
    match_inc   = match_q + 4'd1;
    unique case (state_q)
      SEARCH: if (v_fall) begin
        ref_line_d  = line_period_d;
        ref_frame_d = frame_lines_d;
        match_d     = '0;
        state_d     = ACQUIRE;
      end
      ACQUIRE: if (v_fall) begin
        if (line_period_d == ref_line_q && frame_lines_d == ref_frame_q) begin
          match_d = match_inc;
          if (match_inc >= LOCK_N) state_d = LOCKED;
        end else begin
          ref_line_d  = line_period_d;
          ref_frame_d = frame_lines_d;
          match_d     = '0;
        end
      end
      LOCKED: begin
        if ((h_fall && line_period_d != ref_line_q) ||
            (v_fall && frame_lines_d != ref_frame_q) || pol_chg)
          state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
    if (h_to || v_to) state_d = SEARCH;
  end

  // Counters are aligned with the sample held in dly_q, so coordinates and colour match.
  always_comb begin
    locked_d  = (state_d == LOCKED);
    in_area   = (h_cnt_q >= H_LO) && (h_cnt_q < H_HI) && (v_cnt_q >= V_LO) && (v_cnt_q < V_HI);
    active_d  = locked_q && in_area;
    pix_x_d   = active_d ? 10'(h_cnt_q - H_LO) : '0;
    pix_y_d   = active_d ? 10'(v_cnt_q - V_LO) : '0;
    pix_rgb_d = active_d ? dly_q[2:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= SYNC_IDLE;
      sync2_q       <= SYNC_IDLE;
      dly_q         <= SYNC_IDLE;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      line_period_q <= '0;
      frame_lines_q <= '0;
      state_q       <= SEARCH;
      ref_line_q    <= '0;
      ref_frame_q   <= '0;
      match_q       <= '0;
      locked_q      <= 1'b0;
      active_q      <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      h_pol_q       <= 1'b0;
      v_pol_q       <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      dly_q         <= dly_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      line_period_q <= line_period_d;
      frame_lines_q <= frame_lines_d;
      state_q       <= state_d;
      ref_line_q    <= ref_line_d;
      ref_frame_q   <= ref_frame_d;
      match_q       <= match_d;
      locked_q      <= locked_d;
      active_q      <= active_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
      h_pol_q       <= h_pol_d;
      v_pol_q       <= v_pol_d;
    end
  end

  assign locked      = locked_q;
  assign line_period = line_period_q;
  assign frame_lines = frame_lines_q;
  assign active      = active_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign h_pol       = h_pol_q;
  assign v_pol       = v_pol_q;

endmodule

// File: tb/tb_vga_sync_capture.sv
// Directed bench for vga_sync_capture on a scaled-down raster (100 clk x 20 lines) so that
// lock, loss of lock, timeout, reset and polarity cases all fit in a short run.
module tb_vga_sync_capture;
  localparam int HT = 100, HS = 8, HSTART = 20, HACT = 64;
  localparam int VT = 20, VS = 2, VSTART = 4, VACT = 12;

  logic clk = 1'b0, rst = 1'b1;
  logic h_sync = 1'b1, v_sync = 1'b1, R = 1'b0, G = 1'b0, B = 1'b0;
  logic        locked, active, h_pol, v_pol;
  logic [11:0] line_period;
  logic [10:0] frame_lines;
  logic [9:0]  pix_x, pix_y;
  logic [2:0]  pix_rgb;

  vga_sync_capture #(.H_START(HSTART), .H_ACTIVE(HACT), .V_START(VSTART),
                     .V_ACTIVE(VACT), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync), .R(R), .G(G), .B(B),
    .locked(locked), .line_period(line_period), .frame_lines(frame_lines),
    .active(active), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .h_pol(h_pol), .v_pol(v_pol));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int pf[4], pl[4], pc[4];
  int of, ol, oc;
  int rgb_hits = 0, phase = 0;
  int short_f = 4, short_l = 6, hold_f = 8, rst_f = 11;
  logic inv = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic bit at(input int f, input int l, input int c);
    return of == f && ol == l && oc == c;
  endfunction

  // Outputs read at a negedge describe the sample driven four negedges earlier.
  task automatic check_obs();
    if (phase == 1) begin
      if (of == 3 && pix_rgb != 3'b000) rgb_hits++;
      if (of == -1 && oc == 4044) chk("hold_locked", locked, 1);
      if (of == -1 && oc == 4045) chk("timeout_unlock", locked, 0);
      if (at(2, 10, 0)) chk("pre_lock", locked, 0);
      if (at(3, 1, 0)) begin
        chk("lock", locked, 1);
        chk("line_period", line_period, 100);
        chk("frame_lines", frame_lines, 20);
      end
      if (at(3, 4, 19)) chk("before_first_px", active, 0);
      if (at(3, 4, 20)) begin
        chk("first_px_act", active, 1);
        chk("first_px_x", pix_x, 0);
        chk("first_px_y", pix_y, 0);
      end
      if (at(3, 9, 30)) begin
        chk("mark_rgb", pix_rgb, 5);
        chk("mark_x", pix_x, 10);
        chk("mark_y", pix_y, 5);
      end
      if (at(3, 15, 83)) begin
        chk("last_px_act", active, 1);
        chk("last_px_x", pix_x, 63);
        chk("last_px_y", pix_y, 11);
      end
      if (at(3, 15, 84)) chk("after_last_px", active, 0);
      if (at(3, 16, 20)) chk("below_area", active, 0);
      if (at(4, 0, 0)) chk("rgb_hits", rgb_hits, 1);
      if (at(4, 6, 90)) chk("still_locked", locked, 1);
      if (at(4, 7, 0)) chk("short_line_unlock", locked, 0);
      if (at(4, 7, 5)) chk("short_period", line_period, 99);
      if (at(6, 10, 0)) chk("relock_pending", locked, 0);
      if (at(7, 1, 0)) chk("relocked", locked, 1);
      if (at(8, 4, 10)) chk("period_saturated", line_period, 4095);
      if (at(10, 10, 0)) chk("post_to_pending", locked, 0);
      if (at(11, 2, 0)) chk("post_to_locked", locked, 1);
    end
    if (phase == 2 && at(6, 4, 20)) begin
`ifdef SYNC_POL_DETECT_EN
      chk("inv_h_pol", h_pol, 1);
      chk("inv_v_pol", v_pol, 1);
      chk("inv_locked", locked, 1);
      chk("inv_active", active, 1);
      chk("inv_pix_x", pix_x, 0);
      chk("inv_pix_y", pix_y, 0);
      chk("inv_period", line_period, 100);
      chk("inv_frame", frame_lines, 20);
`else
      chk("inv_h_pol", h_pol, 0);
      chk("inv_v_pol", v_pol, 0);
      chk("inv_active", active, 0);
`endif
    end
  endtask

  task automatic step(input int f, input int l, input int c,
                      input logic hs, input logic vs, input logic [2:0] rgb);
    @(negedge clk);
    of = pf[3]; ol = pl[3]; oc = pc[3];
    for (int i = 3; i > 0; i--) begin
      pf[i] = pf[i-1]; pl[i] = pl[i-1]; pc[i] = pc[i-1];
    end
    pf[0] = f; pl[0] = l; pc[0] = c;
    check_obs();
    h_sync = hs;
    v_sync = vs;
    {R, G, B} = rgb;
  endtask

  task automatic run_frames(input int first, input int last);
    for (int f = first; f <= last; f++) begin
      for (int l = 0; l < VT; l++) begin
        int len;
        len = (f == short_f && l == short_l) ? HT - 1 : HT;
        for (int c = 0; c < len; c++) begin
          if (f == hold_f && l == 3 && c == 50)
            for (int j = 0; j < 5000; j++) step(-1, 0, j, 1'b1 ^ inv, 1'b1 ^ inv, 3'b000);
          if (f == rst_f && l == 8 && c == 40) rst = 1'b1;
          step(f, l, c, inv ^ (c >= HS), inv ^ (l >= VS),
               (l == VSTART + 5 && c == HSTART + 10) ? 3'b101 : 3'b000);
          if (rst) begin
            @(posedge clk);
            #1;
            chk("mid_rst_locked", locked, 0);
            chk("mid_rst_period", line_period, 0);
            chk("mid_rst_frame", frame_lines, 0);
            chk("mid_rst_active", active, 0);
            chk("mid_rst_x", pix_x, 0);
            chk("mid_rst_rgb", pix_rgb, 0);
            rst = 1'b0;
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      pf[i] = -2; pl[i] = 0; pc[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_period", line_period, 0);
    chk("rst_frame", frame_lines, 0);
    chk("rst_active", active, 0);
    chk("rst_rgb", pix_rgb, 0);
    chk("rst_h_pol", h_pol, 0);
    rst = 1'b0;
    phase = 1;
    run_frames(0, 11);

    phase = 2;
    inv = 1'b1;
    short_f = -100;
    hold_f = -100;
    rst_f = -100;
    rst = 1'b1;
    repeat (3) step(-2, 0, 0, 1'b0, 1'b0, 3'b000);
    rst = 1'b0;
    run_frames(0, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
